hamming_decode_arbiter: RTL
===========================

Name: hamming_decode_arbiter

Overview:
- Shares one combinational hamming_decoder (Hamming(7,4)) instance between NREQ requester channels.
- Round-robin arbitration with a valid/ready handshake on each channel; decodes the granted codeword the same cycle.
- Registers the result: corrected data, channel ID, syndrome and corrected flag.
- Keeps a saturating corrected-error counter. Sits between the receive-side word sources and the data consumer.

Parameters:
- NREQ, 4, number of requester channels (2..8).
- CNT_W, 16, width of the corrected-error counter.
- CH_W, $clog2(NREQ), width of the channel ID (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-channel codeword valid.
- req_data  in  7*NREQ  per-channel received codeword; channel i occupies bits [7i+6:7i].
- req_ready  out  NREQ  per-channel accept; one-hot or zero.
- out_valid  out  1  result register holds an undelivered result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  4  recovered data bits, after correction.
- out_chan  out  CH_W  source channel of the result.
- out_syn  out  3  decoder syndrome, unmodified.
- out_corrected  out  1  out_syn != 0.
- clr_count  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of accepted words with nonzero syndrome.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values (asserted asynchronously, held while rst_n = 0):
  - out_valid = 0; out_data, out_chan, out_syn, out_corrected = 0.
  - err_count = 0; rr_ptr = 0; FSM = EMPTY.
- Reset mid-handshake drops any held result with no delivery, and drops any request being accepted.
- FSM states:
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
- Slot-free condition: free = (state == EMPTY) | (out_ready).
- Grant: when free, pick the first channel with req_valid = 1, searching from rr_ptr upward modulo NREQ.
  - req_ready[g] = 1 for the granted channel only. All req_ready are 0 when not free.
  - req_ready is combinational from req_valid, state and out_ready.
  - Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] & req_ready[g]):
  - Route req_data[g] to the decoder.
  - On the next edge, register w -> out_data, s -> out_syn, (s != 0) -> out_corrected, g -> out_chan.
  - Latency: 1 cycle from accept to out_valid.
- Transitions:
  - EMPTY + accept -> FULL. EMPTY, no accept -> EMPTY.
  - FULL + out_ready + accept -> FULL, with new result (back-to-back, 1 word/cycle).
  - FULL + out_ready, no accept -> EMPTY.
  - FULL, !out_ready -> FULL; outputs stable, all req_ready = 0.
- rr_ptr: on accept, becomes (g + 1) mod NREQ. Otherwise unchanged.
  - Fairness: a continuously valid channel waits at most NREQ-1 accepts.
- Error counter:
  - On accept with nonzero syndrome, increments by 1 and saturates at 2^CNT_W - 1.
  - clr_count has priority: clear and increment in the same cycle gives 0.
- Decoder: syndrome and data semantics are exactly those of hamming_decoder.
  - A single-bit error is corrected.
  - A double-bit error is miscorrected, with no detection required.
- No output depends combinationally on req_data.

Test Plan:
- Reset, then ch0 valid with 7'b1111111, out_ready = 1 -> req_ready = 4'b0001 same cycle; next cycle out_valid = 1, out_data = 4'b1111, out_syn = 0, out_corrected = 0, out_chan = 0, err_count = 0.
- ch2 sends 7'b0000100 (single flipped data bit) -> out_data = 4'b0000, out_corrected = 1, out_syn != 0, out_chan = 2, err_count = 1.
- All 4 channels valid continuously, out_ready = 1 -> grants cycle 0,1,2,3,0,... one per cycle; out_chan follows the same sequence one cycle later.
- out_ready = 0 while FULL, for 5 cycles, with requests pending -> outputs stable, req_ready = 0. When out_ready = 1, the next grant goes to the rr_ptr-ordered channel.
- CNT_W = 2: 5 corrupted words -> err_count 1,2,3,3,3. clr_count coincident with a corrupted accept -> err_count = 0.
- rst_n pulled low asynchronously while FULL -> out_valid = 0 and err_count = 0 immediately, without a clock edge. After release, the first grant goes to the lowest valid channel from 0.

Source files
------------

// File: rtl/hamming_decode_arbiter.sv
// Round-robin arbiter in front of one shared Hamming(7,4) decoder.
// The granted channel's codeword is decoded in the accept cycle and the
// result (data, channel, syndrome, corrected flag) is held in a one-entry
// output register with a valid/ready handshake.
//
// Codeword layout (bit index = Hamming position - 1):
//   bit0 = p1, bit1 = p2, bit2 = d0, bit3 = p4, bit4 = d1, bit5 = d2, bit6 = d3
// The syndrome is the 1-based position of a single flipped bit (0 = clean).

module hamming_decoder (
  input  logic [6:0] code,
  output logic [3:0] data,
  output logic [2:0] syn
);

  logic [6:0] fixed;

  // Each syndrome bit checks the positions whose index has that bit set.
  assign syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
  assign syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
  assign syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];

  // Flip the bit at the position the syndrome points to.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_fix
      assign fixed[gi] = code[gi] ^ (syn == 3'(gi + 1));
    end
  endgenerate

  assign data = {fixed[6], fixed[5], fixed[4], fixed[2]};

endmodule

module hamming_decode_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  parameter int CH_W  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [7*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_data,
  output logic [CH_W-1:0]     out_chan,
  output logic [2:0]          out_syn,
  output logic                out_corrected,
  input  logic                clr_count,
  output logic [CNT_W-1:0]    err_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_next;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic              free;
  logic              accept;
  logic [6:0]        dec_code;
  logic [3:0]        dec_data;
  logic [2:0]        dec_syn;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NREQ - 1);

  assign free      = (state == EMPTY) | out_ready;
  assign accept    = free & gnt_found;
  assign out_valid = (state == FULL);

  // First valid channel at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(cand);
      end
    end
  end

  // One-hot ready for the granted channel, only when the slot can take a word.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign dec_code = req_data[7*gnt_idx +: 7];

  hamming_decoder u_dec (
    .code (dec_code),
    .data (dec_data),
    .syn  (dec_syn)
  );

  // Next-state: a new accept always refills the slot; a drained slot empties.
  always_comb begin
    state_next = state;
    if (accept)    state_next = FULL;
    else if (free) state_next = EMPTY;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Capture the decoded result and advance the round-robin pointer on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data      <= '0;
      out_chan      <= '0;
      out_syn       <= '0;
      out_corrected <= 1'b0;
      rr_ptr        <= '0;
    end else if (accept) begin
      out_data      <= dec_data;
      out_chan      <= gnt_idx;
      out_syn       <= dec_syn;
      out_corrected <= (dec_syn != 3'd0);
      rr_ptr        <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Saturating count of accepted words that needed correction; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (accept && (dec_syn != 3'd0) && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
